muldiv_sequencer: RTL

//   Multi-cycle execute unit for RV32M MUL/DIV/REM ops, sitting beside the single-cycle ALU in EX.

---
 rtl/muldiv_sequencer_if.sv | 24 ++
 rtl/muldiv_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the EX stage and the multi-cycle M-extension unit.
// The master side issues the op; the slave side is the sequencer itself.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_valid;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  logic            o_ready;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_funct3, i_rs1, i_rs2, i_flush,
    input  o_ready, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_funct3, i_rs1, i_rs2, i_flush,
    output o_ready, o_valid, o_result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M execute unit: radix-2 shift-add multiply / restoring divide over XLEN cycles.
// o_ready doubles as the pipeline stall for M ops; o_valid is a one-cycle result strobe.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_sequencer_if.slave   bus
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic            r_sign;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_md;
  logic            r_ready;
  logic            r_valid;
  logic [XLEN-1:0] r_result;

  // Accept-time decode
  logic            w_accept;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_sign_in;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;

  // Iteration step
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_mhi;
  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_hi_n;
  logic [XLEN-1:0] w_lo_n;

  // Final result formation
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_final;

  always_comb begin
    w_accept   = bus.i_valid & r_ready & ~bus.i_flush;
    w_is_div   = bus.i_funct3[2];
    // MULHU/DIVU/REMU are fully unsigned; MULHSU keeps rs1 signed only.
    w_a_signed = w_is_div ? ~bus.i_funct3[0] : (bus.i_funct3[1:0] != 2'b11);
    w_b_signed = w_is_div ? ~bus.i_funct3[0] : ~bus.i_funct3[1];
    w_sa       = w_a_signed & bus.i_rs1[XLEN-1];
    w_sb       = w_b_signed & bus.i_rs2[XLEN-1];
    w_mag_a    = w_sa ? -bus.i_rs1 : bus.i_rs1;
    w_mag_b    = w_sb ? -bus.i_rs2 : bus.i_rs2;
    w_sign_in  = (w_is_div & bus.i_funct3[1]) ? w_sa : (w_sa ^ w_sb);

    w_div0     = w_is_div & (bus.i_rs2 == '0);
    w_ovf      = w_is_div & ~bus.i_funct3[0]
               & (bus.i_rs1 == {1'b1, {(XLEN-1){1'b0}}})
               & (bus.i_rs2 == '1);
    w_special  = w_div0 | w_ovf;

    w_special_res = '0;
    if (w_div0) begin
      w_special_res = bus.i_funct3[1] ? bus.i_rs1 : '1;
    end else if (w_ovf) begin
      w_special_res = bus.i_funct3[1] ? '0 : bus.i_rs1;
    end
  end

  always_comb begin
    // Multiply: r_lo holds the remaining multiplier bits, r_hi the upper accumulator.
    w_sum = {1'b0, r_hi} + {1'b0, r_md};
    w_mhi = r_lo[0] ? w_sum : {1'b0, r_hi};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    w_sh    = {r_hi, r_lo[XLEN-1]};
    w_trial = w_sh - {1'b0, r_md};

    if (r_op[2]) begin
      w_hi_n = w_trial[XLEN] ? w_sh[XLEN-1:0] : w_trial[XLEN-1:0];
      w_lo_n = {r_lo[XLEN-2:0], ~w_trial[XLEN]};
    end else begin
      w_hi_n = w_mhi[XLEN:1];
      w_lo_n = {w_mhi[0], r_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    w_prod     = {w_hi_n, w_lo_n};
    w_prod_fix = r_sign ? -w_prod : w_prod;
    w_quot_fix = r_sign ? -w_lo_n : w_lo_n;
    w_rem_fix  = r_sign ? -w_hi_n : w_hi_n;

    if (r_op == 3'b000) begin
      w_final = w_prod_fix[XLEN-1:0];
    end else if (!r_op[2]) begin
      w_final = w_prod_fix[2*XLEN-1:XLEN];
    end else if (!r_op[1]) begin
      w_final = w_quot_fix;
    end else begin
      w_final = w_rem_fix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_sign   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_md     <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.i_funct3;
            r_sign  <= w_sign_in;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_ready <= 1'b0;
            if (w_is_div) begin
              r_lo <= w_mag_a;
              r_md <= w_mag_b;
            end else begin
              r_lo <= w_mag_b;
              r_md <= w_mag_a;
            end
            if (w_special) begin
              r_result <= w_special_res;
              r_valid  <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end

        ST_RUN: begin
          if (bus.i_flush) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + 1'b1;
            // The result register captures the last iteration's outcome directly.
            if (r_cnt == CW'(XLEN - 1)) begin
              r_result <= w_final;
              r_valid  <= 1'b1;
              r_state  <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ready  = r_ready;
  // A flush arriving in the result cycle suppresses the strobe in that same cycle.
  assign bus.o_valid  = r_valid & ~bus.i_flush;
  assign bus.o_result = r_result;

endmodule
